// File: rtl/nl2_dbank_scrub_sched.sv
// Background ECC scrub scheduler and host/scrub arbiter for the dbank command port.
// Optional starvation guard: define NL2_SCRUB_STARVE_GUARD_EN to force scrub after STARVE_LIMIT denials.
module nl2_dbank_scrub_sched #(
    parameter int BNK_ADDR_SIZE = 20,
    parameter int CMD_W         = 64,
    parameter int LINE_ADR      = 6,
    parameter int INTERVAL_SIZE = 16,
    parameter int STARVE_LIMIT  = 15
) (
    input  logic                              dbank_clk,
    input  logic                              rst_a,
    input  logic                              init_done,
    input  logic                              scrub_enable,
    input  logic [INTERVAL_SIZE-1:0]          scrub_interval,
    input  logic [BNK_ADDR_SIZE-LINE_ADR-1:0] scrub_last_line,
    input  logic                              host_cmd_valid,
    input  logic [CMD_W-1:0]                  host_cmd_data,
    output logic                              host_cmd_accept,
    output logic                              bnk_cmd_valid,
    output logic [CMD_W-1:0]                  bnk_cmd_data,
    output logic                              bnk_cmd_scrub,
    input  logic                              bnk_cmd_accept,
    input  logic                              scrub_rsp_valid,
    input  logic                              scrub_rsp_sbe,
    input  logic                              scrub_rsp_dbe,
    output logic [15:0]                       sbe_cnt,
    output logic [15:0]                       dbe_cnt,
    output logic [BNK_ADDR_SIZE-LINE_ADR-1:0] dbe_line,
    output logic                              scrub_busy,
    output logic                              scrub_pass_done
);

    localparam int LINE_W = BNK_ADDR_SIZE - LINE_ADR;

    if (CMD_W < BNK_ADDR_SIZE || STARVE_LIMIT < 1) begin : g_param_check
        $error("nl2_dbank_scrub_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_RSP} state_t;

    state_t                   state_reg, state_next;
    logic [INTERVAL_SIZE-1:0] intv_cnt_reg, intv_cnt_next;
    logic [LINE_W-1:0]        line_reg, line_next;
    logic                     lock_valid_reg, lock_valid_next;
    logic                     lock_scrub_reg, lock_scrub_next;
    logic                     pass_done_reg, pass_done_next;
    logic [LINE_W-1:0]        dbe_line_reg, dbe_line_next;
    logic [15:0]              err_cnt_reg [2];
    logic [1:0]               err_inc;

    logic                     scrub_go;
    logic                     scrub_req;
    logic                     grant_scrub;
    logic                     scrub_hs;
    logic                     rsp_take;
    logic                     force_scrub;
    logic [CMD_W-1:0]         scrub_payload;

    assign scrub_go = scrub_enable & init_done;
    assign rsp_take = (state_reg == S_RSP) & scrub_rsp_valid;

`ifdef NL2_SCRUB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;

    assign force_scrub = (starve_cnt_reg >= STARVE_W'(STARVE_LIMIT));

    // Counts only cycles where a pending scrub lost to the host; saturates at the limit.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (scrub_hs) begin
            starve_cnt_next = '0;
        end else if (scrub_req && bnk_cmd_valid && !grant_scrub && !force_scrub) begin
            starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
        end
    end

    always_ff @(posedge dbank_clk) begin
        if (!rst_a) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`else
    assign force_scrub = 1'b0;
`endif

    // State register and datapath registers
    always_ff @(posedge dbank_clk) begin
        if (!rst_a) begin
            state_reg      <= S_IDLE;
            intv_cnt_reg   <= '0;
            line_reg       <= '0;
            lock_valid_reg <= 1'b0;
            lock_scrub_reg <= 1'b0;
            pass_done_reg  <= 1'b0;
            dbe_line_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            intv_cnt_reg   <= intv_cnt_next;
            line_reg       <= line_next;
            lock_valid_reg <= lock_valid_next;
            lock_scrub_reg <= lock_scrub_next;
            pass_done_reg  <= pass_done_next;
            dbe_line_reg   <= dbe_line_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next     = state_reg;
        intv_cnt_next  = intv_cnt_reg;
        line_next      = line_reg;
        pass_done_next = 1'b0;
        dbe_line_next  = dbe_line_reg;

        case (state_reg)
            S_IDLE: begin
                if (scrub_go) begin
                    state_next    = S_WAIT;
                    intv_cnt_next = scrub_interval;
                end
            end
            S_WAIT: begin
                if (!scrub_go) begin
                    state_next = S_IDLE;
                end else if (intv_cnt_reg == '0) begin
                    state_next = S_REQ;
                end else begin
                    intv_cnt_next = intv_cnt_reg - INTERVAL_SIZE'(1);
                end
            end
            S_REQ: begin
                // A scrub already locked onto the port must finish its handshake.
                if (scrub_hs) begin
                    state_next = S_RSP;
                end else if (!scrub_go && !(lock_valid_reg && lock_scrub_reg)) begin
                    state_next = S_IDLE;
                end
            end
            S_RSP: begin
                if (scrub_rsp_valid) begin
                    state_next    = scrub_go ? S_WAIT : S_IDLE;
                    intv_cnt_next = scrub_interval;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (rsp_take) begin
            if (line_reg >= scrub_last_line) begin
                line_next      = '0;
                pass_done_next = 1'b1;
            end else begin
                line_next = line_reg + LINE_W'(1);
            end
            if (scrub_rsp_dbe && err_cnt_reg[1] == 16'h0000) begin
                dbe_line_next = line_reg;
            end
        end

        if (bnk_cmd_valid && !bnk_cmd_accept) begin
            lock_valid_next = 1'b1;
            lock_scrub_next = grant_scrub;
        end else begin
            lock_valid_next = 1'b0;
            lock_scrub_next = 1'b0;
        end
    end

    // Output / arbitration logic
    always_comb begin
        scrub_req = (state_reg == S_REQ);
        if (lock_valid_reg) begin
            grant_scrub = lock_scrub_reg;
        end else begin
            grant_scrub = scrub_req & (~host_cmd_valid | force_scrub);
        end

        scrub_payload                      = '0;
        scrub_payload[BNK_ADDR_SIZE-1:0]   = {line_reg, {LINE_ADR{1'b0}}};

        bnk_cmd_valid   = grant_scrub | host_cmd_valid | lock_valid_reg;
        bnk_cmd_scrub   = grant_scrub;
        if (grant_scrub) begin
            bnk_cmd_data = scrub_payload;
        end else if (bnk_cmd_valid) begin
            bnk_cmd_data = host_cmd_data;
        end else begin
            bnk_cmd_data = '0;
        end
        host_cmd_accept = bnk_cmd_accept & bnk_cmd_valid & ~grant_scrub;
        scrub_hs        = bnk_cmd_accept & grant_scrub;
        scrub_busy      = (state_reg != S_IDLE);
    end

    // Index 0 counts corrected single-bit errors, index 1 double-bit errors; dbe dominates.
    assign err_inc[0] = rsp_take & scrub_rsp_sbe & ~scrub_rsp_dbe;
    assign err_inc[1] = rsp_take & scrub_rsp_dbe;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_err_cnt
            always_ff @(posedge dbank_clk) begin
                if (!rst_a) begin
                    err_cnt_reg[gi] <= 16'h0000;
                end else if (err_inc[gi] && err_cnt_reg[gi] != 16'hFFFF) begin
                    err_cnt_reg[gi] <= err_cnt_reg[gi] + 16'h0001;
                end
            end
        end
    endgenerate

    assign sbe_cnt         = err_cnt_reg[0];
    assign dbe_cnt         = err_cnt_reg[1];
    assign dbe_line        = dbe_line_reg;
    assign scrub_pass_done = pass_done_reg;

endmodule

// File: tb/tb_nl2_dbank_scrub_sched.sv
// Directed self-checking bench for nl2_dbank_scrub_sched (default parameters).
module tb_nl2_dbank_scrub_sched;

    logic        dbank_clk = 1'b0;
    logic        rst_a;
    logic        init_done;
    logic        scrub_enable;
    logic [15:0] scrub_interval;
    logic [13:0] scrub_last_line;
    logic        host_cmd_valid;
    logic [63:0] host_cmd_data;
    logic        host_cmd_accept;
    logic        bnk_cmd_valid;
    logic [63:0] bnk_cmd_data;
    logic        bnk_cmd_scrub;
    logic        bnk_cmd_accept;
    logic        scrub_rsp_valid;
    logic        scrub_rsp_sbe;
    logic        scrub_rsp_dbe;
    logic [15:0] sbe_cnt;
    logic [15:0] dbe_cnt;
    logic [13:0] dbe_line;
    logic        scrub_busy;
    logic        scrub_pass_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    nl2_dbank_scrub_sched dut (
        .dbank_clk       (dbank_clk),
        .rst_a           (rst_a),
        .init_done       (init_done),
        .scrub_enable    (scrub_enable),
        .scrub_interval  (scrub_interval),
        .scrub_last_line (scrub_last_line),
        .host_cmd_valid  (host_cmd_valid),
        .host_cmd_data   (host_cmd_data),
        .host_cmd_accept (host_cmd_accept),
        .bnk_cmd_valid   (bnk_cmd_valid),
        .bnk_cmd_data    (bnk_cmd_data),
        .bnk_cmd_scrub   (bnk_cmd_scrub),
        .bnk_cmd_accept  (bnk_cmd_accept),
        .scrub_rsp_valid (scrub_rsp_valid),
        .scrub_rsp_sbe   (scrub_rsp_sbe),
        .scrub_rsp_dbe   (scrub_rsp_dbe),
        .sbe_cnt         (sbe_cnt),
        .dbe_cnt         (dbe_cnt),
        .dbe_line        (dbe_line),
        .scrub_busy      (scrub_busy),
        .scrub_pass_done (scrub_pass_done)
    );

    always #5 dbank_clk = ~dbank_clk;

    task automatic step();
        @(posedge dbank_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps until a scrub command is on the port, bounded.
    task automatic wait_scrub(output int n);
        n = 0;
        while (!(bnk_cmd_valid && bnk_cmd_scrub) && n < 60) begin
            step();
            n++;
        end
        chk("scrub_seen", {63'd0, bnk_cmd_valid & bnk_cmd_scrub}, 64'd1);
    endtask

    // One scrub read: wait, check address, handshake, respond one cycle later.
    task automatic scrub_txn(input string tag, input logic [63:0] exp_addr, input logic sbe,
                             input logic dbe, input logic exp_pass, input int exp_wait);
        int n;
        wait_scrub(n);
        if (exp_wait >= 0) chk({tag, "_wait"}, 64'(n), 64'(exp_wait));
        chk({tag, "_addr"}, bnk_cmd_data, exp_addr);
        $display("scrub %s addr=%0h wait=%0d", tag, bnk_cmd_data, n);
        step();
        chk({tag, "_rsp_idle"}, {63'd0, bnk_cmd_valid}, 64'd0);
        scrub_rsp_valid = 1'b1;
        scrub_rsp_sbe   = sbe;
        scrub_rsp_dbe   = dbe;
        step();
        scrub_rsp_valid = 1'b0;
        scrub_rsp_sbe   = 1'b0;
        scrub_rsp_dbe   = 1'b0;
        chk({tag, "_pass"}, {63'd0, scrub_pass_done}, {63'd0, exp_pass});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {63'd0, bnk_cmd_valid}, 64'd0);
        chk({tag, "_scrub"}, {63'd0, bnk_cmd_scrub}, 64'd0);
        chk({tag, "_data"}, bnk_cmd_data, 64'd0);
        chk({tag, "_hacc"}, {63'd0, host_cmd_accept}, 64'd0);
        chk({tag, "_sbe"}, 64'(sbe_cnt), 64'd0);
        chk({tag, "_dbe"}, 64'(dbe_cnt), 64'd0);
        chk({tag, "_dline"}, 64'(dbe_line), 64'd0);
        chk({tag, "_busy"}, {63'd0, scrub_busy}, 64'd0);
        chk({tag, "_pass"}, {63'd0, scrub_pass_done}, 64'd0);
    endtask

    initial begin
        int n;
        int s;
        int found;
        int exp_first;
        logic [63:0] hdata;

        rst_a = 1'b0; init_done = 1'b0; scrub_enable = 1'b0;
        scrub_interval = 16'd4; scrub_last_line = 14'd3;
        host_cmd_valid = 1'b0; host_cmd_data = 64'd0; bnk_cmd_accept = 1'b0;
        scrub_rsp_valid = 1'b0; scrub_rsp_sbe = 1'b0; scrub_rsp_dbe = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");

        // Basic walk over lines 0..3, wrap back to 0.
        rst_a = 1'b1; init_done = 1'b1; scrub_enable = 1'b1; bnk_cmd_accept = 1'b1;
        step();
        chk("busy_after_en", {63'd0, scrub_busy}, 64'd1);
        scrub_txn("walk0", 64'h00, 1'b0, 1'b0, 1'b0, 5);
        scrub_txn("walk1", 64'h40, 1'b0, 1'b0, 1'b0, 5);
        scrub_txn("walk2", 64'h80, 1'b0, 1'b0, 1'b0, 5);
        scrub_txn("walk3", 64'hC0, 1'b0, 1'b0, 1'b1, 5);
        step();
        chk("pass_pulse_end", {63'd0, scrub_pass_done}, 64'd0);
        scrub_txn("walk4", 64'h00, 1'b0, 1'b0, 1'b0, 4);

        // Error accounting over lines 1..5 with last line raised to 7.
        scrub_last_line = 14'd7;
        scrub_txn("err1", 64'h40, 1'b0, 1'b0, 1'b0, 5);
        scrub_txn("err2", 64'h80, 1'b1, 1'b1, 1'b0, 5);
        chk("err2_dbe", 64'(dbe_cnt), 64'd1);
        chk("err2_sbe", 64'(sbe_cnt), 64'd0);
        chk("err2_dline", 64'(dbe_line), 64'd2);
        scrub_txn("err3", 64'hC0, 1'b1, 1'b0, 1'b0, 5);
        scrub_txn("err4", 64'h100, 1'b0, 1'b0, 1'b0, 5);
        scrub_txn("err5", 64'h140, 1'b0, 1'b1, 1'b0, 5);
        chk("err5_dbe", 64'(dbe_cnt), 64'd2);
        chk("err5_sbe", 64'(sbe_cnt), 64'd1);
        chk("err5_dline", 64'(dbe_line), 64'd2);

        // Disable while RSP: finish response, then IDLE; stray response ignored.
        wait_scrub(n);
        chk("dis_addr", bnk_cmd_data, 64'h180);
        step();
        scrub_enable = 1'b0;
        step();
        step();
        chk("dis_rsp_busy", {63'd0, scrub_busy}, 64'd1);
        chk("dis_rsp_valid", {63'd0, bnk_cmd_valid}, 64'd0);
        scrub_rsp_valid = 1'b1;
        step();
        scrub_rsp_valid = 1'b0;
        chk("dis_idle", {63'd0, scrub_busy}, 64'd0);
        scrub_rsp_valid = 1'b1; scrub_rsp_dbe = 1'b1;
        step();
        scrub_rsp_valid = 1'b0; scrub_rsp_dbe = 1'b0;
        step();
        chk("stray_dbe", 64'(dbe_cnt), 64'd2);
        chk("stray_busy", {63'd0, scrub_busy}, 64'd0);
        $display("disable in RSP: busy=%0d dbe_cnt=%0d", scrub_busy, dbe_cnt);
        scrub_enable = 1'b1;
        scrub_txn("resume", 64'h1C0, 1'b0, 1'b0, 1'b1, 6);

        // Host command locked by a stalled bank while scrub becomes pending.
        hdata = 64'hDEAD_BEEF_0000_1234;
        bnk_cmd_accept = 1'b0; host_cmd_valid = 1'b1; host_cmd_data = hdata;
        #1;
        for (int i = 0; i < 7; i++) begin
            chk("lock_valid", {63'd0, bnk_cmd_valid}, 64'd1);
            chk("lock_owner", {63'd0, bnk_cmd_scrub}, 64'd0);
            chk("lock_data", bnk_cmd_data, hdata);
            chk("lock_hacc", {63'd0, host_cmd_accept}, 64'd0);
            step();
        end
        chk("lock_busy", {63'd0, scrub_busy}, 64'd1);
        bnk_cmd_accept = 1'b1;
        #1;
        chk("lock_release_hacc", {63'd0, host_cmd_accept}, 64'd1);
        chk("lock_release_data", bnk_cmd_data, hdata);
        $display("lock hold: host data=%0h accepted", bnk_cmd_data);
        step();
        host_cmd_valid = 1'b0;
        #1;
        scrub_txn("after_lock", 64'h00, 1'b0, 1'b0, 1'b0, 0);

        // Continuous host traffic: starvation behaviour.
`ifdef NL2_SCRUB_STARVE_GUARD_EN
        exp_first = 20;
`else
        exp_first = -1;
`endif
        host_cmd_valid = 1'b1; host_cmd_data = 64'h1111;
        #1;
        s = 0;
        while (s < 40 && !bnk_cmd_scrub) begin
            chk("starve_hacc", {63'd0, host_cmd_accept}, 64'd1);
            step();
            s++;
        end
        found = bnk_cmd_scrub ? s : -1;
        chk("starve_first", 64'(found), 64'(exp_first));
        $display("host flood: first scrub grant at step %0d", found);
        host_cmd_valid = 1'b0;
        #1;
        scrub_txn("starve_rel", 64'h40, 1'b0, 1'b0, 1'b0, 0);

        // Reset mid-REQ.
        bnk_cmd_accept = 1'b0;
        wait_scrub(n);
        chk("rst_req_addr", bnk_cmd_data, 64'h80);
        rst_a = 1'b0;
        step();
        chk_reset_outputs("midreset");
        rst_a = 1'b1; bnk_cmd_accept = 1'b1;
        scrub_txn("post_reset", 64'h00, 1'b0, 1'b0, 1'b0, 6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
